// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, mode and select-code constants
package alu_pkg;
    localparam int ALU_W = 16;
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;
    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_AND    = 4'b1011;
    localparam logic [3:0] SEL_XOR    = 4'b0110;
    localparam logic [3:0] SEL_PASS_A = 4'b1111;
    typedef logic [ALU_W-1:0] word_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid/ready register slot with flush, parameterised by payload width
// Ports: in_valid_i/in_ready_o/in_data_i upstream beat, out_valid_o/out_ready_i/out_data_o
// downstream beat, flush drops the held beat and blocks loading on that edge.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         push;
    always_comb begin
        in_ready_o  = !valid_q || out_ready_i;
        push        = in_valid_i && in_ready_o && !flush;
        valid_d     = !flush && (push || (valid_q && !out_ready_i));
        data_d      = push ? in_data_i : data_q;
        out_valid_o = valid_q;
        out_data_o  = data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/alu_op_pipe.sv
// alu_op_pipe: two-stage valid/ready pipeline around an external 16-bit ALU with chained carry flag
// Ports: in_* operation beat from the sequencer, alu_* operand/result link to the ALU,
// res_* captured result beat to writeback, carry_flag architectural carry, flush drops all.
module alu_op_pipe
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALU_W-1:0] in_a,
    input  logic [ALU_W-1:0] in_b,
    input  logic [3:0]       in_select,
    input  logic             in_mode,
    input  logic             in_cin,
    input  logic             in_use_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [3:0]       alu_select,
    output logic             alu_mode,
    output logic             alu_carry_in,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_compare,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_data,
    output logic             res_carry,
    output logic             res_compare,
    output logic             res_zero,
    output logic [TAG_W-1:0] res_tag,
    output logic             carry_flag
);
    localparam int OP_W  = 2*ALU_W + 7 + TAG_W;
    localparam int RES_W = ALU_W + 3 + TAG_W;
    logic             op_valid, s1_ready, s2_ready, advance;
    logic             op_cin, op_use_carry;
    logic [TAG_W-1:0] op_tag;
    logic             carry_q, carry_d;
    pipe_slot #(.W(OP_W)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   ({in_a, in_b, in_select, in_mode, in_cin, in_use_carry, in_tag}),
        .out_valid_o (op_valid),
        .out_ready_i (s2_ready),
        .out_data_o  ({alu_a, alu_b, alu_select, alu_mode, op_cin, op_use_carry, op_tag})
    );
    pipe_slot #(.W(RES_W)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (op_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   ({alu_result, alu_carry_out, alu_compare, alu_result == '0, op_tag}),
        .out_valid_o (res_valid),
        .out_ready_i (res_ready),
        .out_data_o  ({res_data, res_carry, res_compare, res_zero, res_tag})
    );
    always_comb begin
        advance      = op_valid && s2_ready;
        in_ready     = !flush && s1_ready;
        alu_carry_in = op_use_carry ? carry_q : op_cin;
        // Only arithmetic ops retire a carry; the op loaded on the same edge sees it next cycle.
        carry_d      = (advance && alu_mode == MODE_ARITH) ? alu_carry_out : carry_q;
        carry_flag   = carry_q;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) carry_q <= 1'b0;
        else carry_q <= carry_d;
    end
endmodule

// File: tb/tb_alu_op_pipe.sv
// tb_alu_op_pipe: directed scoreboard bench for alu_op_pipe with a behavioural ALU stand-in
module tb_alu_op_pipe;
    import alu_pkg::*;
    localparam int TAG_W = 4;

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  sel;
        logic        mode, cin, uc;
        logic [3:0]  tag;
        logic [15:0] ed;
        logic        ec, ecmp;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        c, cmp, z;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, res_ready = 1'b1;
    logic [15:0] in_a = '0, in_b = '0;
    logic [3:0]  in_select = '0;
    logic        in_mode = 1'b0, in_cin = 1'b0, in_use_carry = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        in_ready;
    logic [15:0] alu_a, alu_b, alu_result, res_data;
    logic [3:0]  alu_select, res_tag;
    logic        alu_mode, alu_carry_in, alu_carry_out, alu_compare;
    logic        res_valid, res_carry, res_compare, res_zero, carry_flag;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];
    exp_t e;
    int   pop_log[$];
    vec_t cur;

    alu_op_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_select(in_select), .in_mode(in_mode),
        .in_cin(in_cin), .in_use_carry(in_use_carry), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result),
        .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_compare(res_compare), .res_zero(res_zero),
        .res_tag(res_tag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // ALU stand-in: arithmetic adds with carry-in, logic mode ANDs; select is not decoded.
    always_comb begin
        {alu_carry_out, alu_result} = alu_mode ? {1'b0, alu_a & alu_b}
                                               : {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_carry_in};
        alu_compare = (alu_a == alu_b);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && !flush && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got result tag %0h data %0h, expected no result", res_tag, res_data);
            end else begin
                e = sb.pop_front();
                if ({res_data, res_carry, res_compare, res_zero, res_tag} !== {e.d, e.c, e.cmp, e.z, e.tag}) begin
                    errors++;
                    $display("FAIL result: got d=%h c=%b cmp=%b z=%b tag=%h, expected d=%h c=%b cmp=%b z=%b tag=%h",
                             res_data, res_carry, res_compare, res_zero, res_tag, e.d, e.c, e.cmp, e.z, e.tag);
                end
            end
            pop_log.push_back(cyc);
        end
        if (!rst && in_valid && in_ready)
            sb.push_back('{cur.ed, cur.ec, cur.ecmp, cur.ed == 16'h0, cur.tag});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [3:0] sel, logic mode,
                                logic cin, logic uc, logic [3:0] tag, logic [15:0] ed, logic ec, logic ecmp);
        vec_t v;
        v.a = a; v.b = b; v.sel = sel; v.mode = mode; v.cin = cin; v.uc = uc;
        v.tag = tag; v.ed = ed; v.ec = ec; v.ecmp = ecmp;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(vec_t v);
        cur = v;
        in_a = v.a; in_b = v.b; in_select = v.sel; in_mode = v.mode;
        in_cin = v.cin; in_use_carry = v.uc; in_tag = v.tag;
        in_valid = 1'b1;
    endtask

    task automatic issue(vec_t v);
        bit done = 0;
        set_op(v);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        if (!done) chk("issue_timeout", 0, 1);
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n && sb.size() != 0; i++) tick();
        tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    logic [15:0] st_res [8] = '{16'h0001, 16'h1112, 16'h2223, 16'h3334,
                                16'h4445, 16'h5556, 16'h6667, 16'h7778};
    logic [15:0] bp_b   [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

    initial begin
        vec_t bp [4];
        int idx, t0;
        for (int k = 0; k < 4; k++)
            bp[k] = mk(16'hFFFF, bp_b[k], SEL_AND, MODE_LOGIC, 1'b0, 1'b0, 4'(8 + k), bp_b[k], 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_carry", res_carry, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_carry_flag", carry_flag, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_a", alu_a, 0);
        tick();

        issue(mk(16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'h3, 16'h0000, 1'b1, 1'b0));
        issue(mk(16'h0001, 16'h0002, SEL_ADD, MODE_ARITH, 1'b0, 1'b1, 4'h4, 16'h0004, 1'b0, 1'b0));
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_res_valid", res_valid, 1);
        chk("add_res_data", res_data, 16'h0000);
        chk("add_res_carry", res_carry, 1);
        chk("add_res_zero", res_zero, 1);
        chk("add_res_tag", res_tag, 4'h3);
        chk("add_carry_flag", carry_flag, 1);
        chk("chain_alu_carry_in", alu_carry_in, 1);
        tick();
        drain(10);

        issue(mk(16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'h5, 16'h0000, 1'b1, 1'b0));
        issue(mk(16'hF0F0, 16'h0FF0, SEL_AND, MODE_LOGIC, 1'b0, 1'b0, 4'h6, 16'h00F0, 1'b0, 1'b0));
        issue(mk(16'h0001, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b1, 4'h7, 16'h0003, 1'b0, 1'b1));
        in_valid = 1'b0;
        @(negedge clk);
        chk("logic_keeps_carry", carry_flag, 1);
        chk("chain2_alu_carry_in", alu_carry_in, 1);
        chk("logic_res_tag", res_tag, 4'h6);
        tick();
        drain(10);
        chk("chain2_carry_flag", carry_flag, 0);

        pop_log.delete();
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            issue(mk(16'(i * 16'h1111), 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'(i), st_res[i], 1'b0, 1'b0));
        chk("stream_accept_cycles", cyc - t0, 8);
        in_valid = 1'b0;
        drain(20);
        chk("stream_count", pop_log.size(), 8);
        chk("stream_consecutive", pop_log.size() == 8 ? pop_log[7] - pop_log[0] : -1, 7);

        res_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            set_op(bp[idx]);
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        @(negedge clk);
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_res_tag", res_tag, 4'h8);
        tick();
        res_ready = 1'b1;
        for (int k = idx; k < 4; k++) issue(bp[k]);
        in_valid = 1'b0;
        drain(20);

        res_ready = 1'b0;
        issue(mk(16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'h1, 16'h0000, 1'b1, 1'b0));
        issue(mk(16'h00FF, 16'h0F0F, SEL_AND, MODE_LOGIC, 1'b0, 1'b0, 4'h2, 16'h000F, 1'b0, 1'b0));
        set_op(mk(16'h1111, 16'h2222, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'h9, 16'h3333, 1'b0, 1'b0));
        flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_carry", carry_flag, 1);
        chk("pre_flush_res_valid", res_valid, 1);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_res_valid", res_valid, 0);
        chk("flush_carry_flag", carry_flag, 0);
        chk("flush_in_ready_after", in_ready, 1);
        sb.delete();
        tick();
        res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("flush_no_accept", res_valid, 0);
        tick();

        res_ready = 1'b0;
        issue(mk(16'h8001, 16'h8001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 4'hA, 16'h0002, 1'b1, 1'b1));
        issue(mk(16'h1234, 16'h00FF, SEL_AND, MODE_LOGIC, 1'b0, 1'b0, 4'hB, 16'h0034, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_state", {res_valid, res_carry, res_compare, res_tag, carry_flag}, {1'b1, 1'b1, 1'b1, 4'hA, 1'b1});
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_res_valid", res_valid, 0);
        chk("rst2_res_data", res_data, 0);
        chk("rst2_res_carry", res_carry, 0);
        chk("rst2_res_compare", res_compare, 0);
        chk("rst2_res_tag", res_tag, 0);
        chk("rst2_carry_flag", carry_flag, 0);
        chk("rst2_alu_a", alu_a, 0);
        chk("rst2_in_ready", in_ready, 1);
        sb.delete();
        tick();
        res_ready = 1'b1;
        issue(mk(16'h0005, 16'h0007, SEL_ADD, MODE_ARITH, 1'b1, 1'b0, 4'hC, 16'h000D, 1'b0, 1'b0));
        in_valid = 1'b0;
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
